mem_responder: RTL and testbench

- Word-addressed RAM responder at the far end of the datapath's MAR/MDR memory interface.
- Accepts single-word read/write requests from the control unit and the datapath: address from MAR, write data from MDR.
- Inserts a programmable number of wait states, then completes the access and pulses a done strobe back to the control unit.
- Read data is held stable on the MDR's memory-input lines until the next read completes.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 40 ++++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding and default sizing.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 10;
    localparam int DEFAULT_DEPTH       = 512;
    localparam int DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// The read register has its own synchronous clear so the owner can force it to 0.
import mem_pkg::*;

module mem_array #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  rclr_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: only a read or a clear may change it, so it holds between reads.
    always_ff @(posedge clk_i) begin
        if (rclr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM responder behind the MAR/MDR interface.
// Handshake: a request is accepted when exactly one of Mem_read/Mem_write is
// high at an edge in IDLE; Mem_busy rises the next cycle and stays high through
// the single cycle in which Mem_done pulses; strobes seen while busy are ignored.
// Outputs are registered, so they trail the FSM state by one cycle: the RAM
// access is issued while the FSM sits in DONE and lands on the same edge that
// raises Mem_done, which is why Mem_datain is valid whenever Mem_done is high.
import mem_pkg::*;

module mem_responder #(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  Mem_read,
    input  logic                  Mem_write,
    input  logic [ADDR_WIDTH-1:0] MAR_to_chip,
    input  logic [DATA_WIDTH-1:0] Mem_dataout,
    output logic [DATA_WIDTH-1:0] Mem_datain,
    output logic                  Mem_done,
    output logic                  Mem_busy,
    output logic                  Mem_err,
    output logic [1:0]            dbg_state_o
);

    localparam int                    RAM_AW  = $clog2(DEPTH);
    localparam logic [3:0]            WS_L    = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  is_wr_q, is_wr_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  oor;
    logic                  ram_we, ram_re, ram_rclr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign oor = ({1'b0, addr_q} >= DEPTH_L);

    // Next-state, request latching and the RAM command for the current cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        is_wr_d  = is_wr_q;
        done_d   = 1'b0;
        busy_d   = 1'b1;
        err_d    = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_rclr = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Mem_read ^ Mem_write) begin
                    addr_d  = MAR_to_chip;
                    data_d  = Mem_dataout;
                    is_wr_d = Mem_write;
                    cnt_d   = WS_L;
                    busy_d  = 1'b1;
                    state_d = (WS_L != 4'd0) ? WAIT : DONE;
                end else if (Mem_read && Mem_write) begin
                    // Conflicting strobes: drop the request and flag it.
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                err_d   = oor;
                state_d = IDLE;
                if (is_wr_q) begin
                    ram_we = !oor;
                end else if (oor) begin
                    ram_rclr = 1'b1;
                end else begin
                    ram_re = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, latched request and registered status outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            is_wr_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Reset blocks any write in flight and zeroes the read register.
    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_array (
        .clk_i   (clock),
        .we_i    (ram_we & ~clear),
        .re_i    (ram_re & ~clear),
        .rclr_i  (ram_rclr | clear),
        .addr_i  (addr_q[RAM_AW-1:0]),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign Mem_datain  = ram_rdata;
    assign Mem_done    = done_q;
    assign Mem_busy    = busy_q;
    assign Mem_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized checks of mem_responder, run on two instances:
// one with WAIT_STATES=2 (sel=0) and one with WAIT_STATES=0 (sel=1).
module tb_mem_responder;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic        rd, wr;
    logic [9:0]  mar;
    logic [31:0] mdr;
    bit          sel;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] a_datain, b_datain;
    logic        a_done, a_busy, a_err, b_done, b_busy, b_err;
    logic [1:0]  a_state, b_state;

    assign rd_a = rd & ~sel;
    assign wr_a = wr & ~sel;
    assign rd_b = rd & sel;
    assign wr_b = wr & sel;

    mem_responder #(.WAIT_STATES(2)) u_dut_ws2 (
        .clock       (clock),
        .clear       (clear),
        .Mem_read    (rd_a),
        .Mem_write   (wr_a),
        .MAR_to_chip (mar),
        .Mem_dataout (mdr),
        .Mem_datain  (a_datain),
        .Mem_done    (a_done),
        .Mem_busy    (a_busy),
        .Mem_err     (a_err),
        .dbg_state_o (a_state)
    );

    mem_responder #(.WAIT_STATES(0)) u_dut_ws0 (
        .clock       (clock),
        .clear       (clear),
        .Mem_read    (rd_b),
        .Mem_write   (wr_b),
        .MAR_to_chip (mar),
        .Mem_dataout (mdr),
        .Mem_datain  (b_datain),
        .Mem_done    (b_done),
        .Mem_busy    (b_busy),
        .Mem_err     (b_err),
        .dbg_state_o (b_state)
    );

    logic [31:0] o_datain;
    logic        o_done, o_busy, o_err;
    logic [1:0]  o_state;
    assign o_datain = sel ? b_datain : a_datain;
    assign o_done   = sel ? b_done   : a_done;
    assign o_busy   = sel ? b_busy   : a_busy;
    assign o_err    = sel ? b_err    : a_err;
    assign o_state  = sel ? b_state  : a_state;

    // ---------------- reference model / scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          ws_of [2] = '{2, 0};
    logic [31:0] model [2][512];
    bit          valid [2][512];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " done"},   {31'd0, o_done}, 32'd0);
        check({tag, " busy"},   {31'd0, o_busy}, 32'd0);
        check({tag, " err"},    {31'd0, o_err},  32'd0);
        check({tag, " datain"}, o_datain, last_rd[sel]);
        check({tag, " state"},  {30'd0, o_state}, 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        clear = 1'b1;
        repeat (n) @(posedge clock);
        #1 clear = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic do_req(input bit r, input bit w, input logic [9:0] a, input logic [31:0] d);
        int ws;
        bit oor;
        ws  = ws_of[sel];
        oor = (a >= 10'd512);
        rd = r; wr = w; mar = a; mdr = d;
        @(posedge clock);
        #1;
        rd = 1'b0; wr = 1'b0;
        mar = 10'($urandom);
        mdr = $urandom;
        if (r && w) begin
            @(negedge clock);
            check("conflict err",  {31'd0, o_err},  32'd1);
            check("conflict done", {31'd0, o_done}, 32'd0);
            check("conflict busy", {31'd0, o_busy}, 32'd0);
            @(posedge clock);
            @(negedge clock);
            check("conflict err end",  {31'd0, o_err},  32'd0);
            check("conflict done end", {31'd0, o_done}, 32'd0);
            check("conflict datain",   o_datain, last_rd[sel]);
            return;
        end
        if (r) exp_q.push_back(oor ? 32'd0 : model[sel][a[8:0]]);
        @(negedge clock);
        for (int k = 0; k <= ws + 2; k++) begin
            if (k > 0) begin
                @(posedge clock);
                @(negedge clock);
            end
            if (k == ws + 1) begin
                if (r) begin
                    last_rd[sel] = exp_q.pop_front();
                end else if (!oor) begin
                    model[sel][a[8:0]] = d;
                    valid[sel][a[8:0]] = 1'b1;
                end
            end
            check($sformatf("done ws=%0d k=%0d", ws, k), {31'd0, o_done}, {31'd0, (k == ws + 1)});
            check($sformatf("busy ws=%0d k=%0d", ws, k), {31'd0, o_busy}, {31'd0, (k <= ws + 1)});
            check($sformatf("err ws=%0d k=%0d", ws, k),  {31'd0, o_err},  {31'd0, (k == ws + 1) && oor});
            check($sformatf("datain ws=%0d k=%0d a=%h", ws, k, a), o_datain, last_rd[sel]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rd = 1'b0; wr = 1'b0; mar = '0; mdr = '0; sel = 1'b0; clear = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clock);
        do_reset(2);
        @(negedge clock);
        sel = 1'b0; check_idle("reset ws2");
        sel = 1'b1; check_idle("reset ws0");

        // Basic write/read with two wait states, then a conflicting request.
        sel = 1'b0;
        do_req(0, 1, 10'h005, 32'hDEADBEEF);
        do_req(1, 0, 10'h005, 32'h0);
        do_req(0, 1, 10'h006, 32'h00C0FFEE);
        do_req(1, 1, 10'h005, 32'h11111111);
        do_req(1, 0, 10'h005, 32'h0);

        // Zero wait states at the top implemented word.
        sel = 1'b1;
        do_req(0, 1, 10'h1FF, 32'h12345678);
        do_req(1, 0, 10'h1FF, 32'h0);

        // Out-of-range accesses must not disturb word 0.
        sel = 1'b0;
        do_req(0, 1, 10'h000, 32'h0BADF00D);
        do_req(0, 1, 10'h200, 32'hFFFFFFFF);
        do_req(1, 0, 10'h200, 32'h0);
        do_req(1, 0, 10'h000, 32'h0);

        // Reset in the middle of a write's wait period.
        do_req(0, 1, 10'h010, 32'h01020304);
        rd = 1'b0; wr = 1'b1; mar = 10'h010; mdr = 32'hAAAA5555;
        @(posedge clock);
        #1 wr = 1'b0;
        @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_idle($sformatf("abort k=%0d", k));
        end
        do_req(1, 0, 10'h010, 32'h0);

        // Randomized traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int n = 0; n < 25; n++) begin
                logic [9:0]  a;
                int          op;
                a  = 10'($urandom_range(0, 639));
                op = $urandom_range(0, 9);
                if (op == 0) begin
                    do_req(1, 1, a, $urandom);
                end else if (op <= 4 && (a >= 10'd512 || valid[sel][a[8:0]])) begin
                    do_req(1, 0, a, $urandom);
                end else begin
                    do_req(0, 1, a, $urandom);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
